bram_dual_client: RTL and testbench

//  Requester-side adapter for a simple-dual-port block RAM: 1 write port, 1 registered read port, read latency 1.

---
 rtl/bram_client_pkg.sv | 14 +
 rtl/bram_client_rsp_fifo.sv | 42 ++++
 rtl/bram_dual_client.sv | 80 ++++++++
 tb/tb_bram_dual_client.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_client_pkg.sv
// bram_client_pkg: shared defaults, width helpers and word type for the BRAM dual client.
package bram_client_pkg;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RSP_DEPTH  = 4;
    localparam int MIN_RSP_DEPTH  = 2;
    typedef logic [DEF_DATA_WIDTH-1:0] rsp_word_t;
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic bit depth_ok(input int depth);
        return depth >= MIN_RSP_DEPTH && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/bram_client_rsp_fifo.sv
// bram_client_rsp_fifo: register FIFO holding read responses; only pointers and count are reset.
module bram_client_rsp_fifo
    import bram_client_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH,
    parameter int WIDTH = DEF_DATA_WIDTH,
    localparam int CW = cnt_width(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/bram_dual_client.sv
// bram_dual_client: valid/ready adapter for a simple-dual-port BRAM with buffered, in-order read responses.
// BRAM_CLIENT_COLLISION_FWD_EN forwards write data on same-address collisions instead of stalling the read.
module bram_dual_client
    import bram_client_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_req_valid,
    output logic                  wr_req_ready,
    input  logic [ADDR_WIDTH-1:0] wr_req_addr,
    input  logic [DATA_WIDTH-1:0] wr_req_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_do
);
    localparam int CW = cnt_width(RSP_DEPTH);
    logic                  pending, collision, credit_ok, rd_fire;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] push_data;
    assign wr_req_ready = 1'b1;
    assign ram_we       = wr_req_valid;
    assign ram_wr_addr  = wr_req_addr;
    assign ram_di       = wr_req_data;
    assign ram_re       = rd_fire;
    assign ram_rd_addr  = rd_req_addr;
    assign collision    = rd_req_valid & wr_req_valid & (rd_req_addr == wr_req_addr);
    // A credit covers both buffered words and the one still in the RAM pipeline.
    assign credit_ok    = ~fifo_full & ((fifo_count + CW'(pending)) < CW'(RSP_DEPTH));
    assign rd_fire      = rd_req_valid & rd_req_ready;
    assign rd_rsp_valid = ~fifo_empty;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pending <= 1'b0;
        else pending <= rd_fire;
    end
`ifdef BRAM_CLIENT_COLLISION_FWD_EN
    logic      fwd;
    rsp_word_t fwd_data;
    assign rd_req_ready = credit_ok;
    assign push_data    = fwd ? DATA_WIDTH'(fwd_data) : ram_do;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) fwd <= 1'b0;
        else fwd <= rd_fire & collision;
    end
    always_ff @(posedge CLK) begin
        if (rd_fire & collision) fwd_data <= rsp_word_t'(wr_req_data);
    end
`else
    // The RAM returns X on a same-address collision, so hold the read one cycle.
    assign rd_req_ready = credit_ok & ~collision;
    assign push_data    = ram_do;
`endif
    bram_client_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (pending),
        .push_data (push_data),
        .pop       (rd_rsp_valid & rd_rsp_ready),
        .pop_data  (rd_rsp_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_bram_dual_client.sv
// tb_bram_dual_client: randomized and directed checks of bram_dual_client against a queue/array reference model.
module tb_bram_dual_client;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_req_valid = 1'b0, wr_req_ready;
    logic [AW-1:0] wr_req_addr = '0;
    logic [DW-1:0] wr_req_data = '0;
    logic          rd_req_valid = 1'b0, rd_req_ready;
    logic [AW-1:0] rd_req_addr = '0;
    logic          rd_rsp_valid, rd_rsp_ready = 1'b1;
    logic [DW-1:0] rd_rsp_data;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_di, ram_do = '0;

    bram_dual_client #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_di(ram_di),
        .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // RAM model: registered read, X on same-address read/write in one cycle.
    logic [DW-1:0] ram [1<<AW];
    always @(posedge CLK) begin
        if (ram_re) ram_do <= (ram_we && ram_wr_addr == ram_rd_addr) ? 'x : ram[ram_rd_addr];
        if (ram_we) ram[ram_wr_addr] <= ram_di;
    end

    int total = 0;
    int bad = 0;
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] q[$];
    logic          acc, took, obs_valid, obs_ready, exp_ready, underflow;
    logic [DW-1:0] obs_data, exp_rsp;

    // Advance one cycle: sample at negedge, update the reference model, return at posedge+1.
    task automatic tick();
        @(negedge CLK);
        obs_valid = rd_rsp_valid;
        obs_ready = rd_req_ready;
        obs_data  = rd_rsp_data;
        acc       = rd_req_valid & rd_req_ready;
        took      = rd_rsp_valid & rd_rsp_ready;
        exp_ready = q.size() < DEPTH;
`ifndef BRAM_CLIENT_COLLISION_FWD_EN
        if (rd_req_valid && wr_req_valid && rd_req_addr == wr_req_addr) exp_ready = 1'b0;
`endif
        underflow = 1'b0;
        exp_rsp   = 'x;
        if (took) begin
            if (q.size() == 0) underflow = 1'b1;
            else exp_rsp = q.pop_front();
        end
        if (acc) q.push_back((wr_req_valid && wr_req_addr == rd_req_addr) ? wr_req_data : ref_mem[rd_req_addr]);
        if (wr_req_valid) ref_mem[wr_req_addr] = wr_req_data;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wr_req_valid = 1'b0;
        rd_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rd_rsp_valid); end
        total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", rd_req_ready); end
        total++; if (ram_re !== 1'b0) begin bad++; $display("FAIL reset_ram_re got=%b want=0", ram_re); end
        total++; if (wr_req_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_req_ready); end
        RST = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < 128; i++) begin
            wr_req_valid = 1'b1;
            wr_req_addr  = AW'(i);
            wr_req_data  = $urandom;
            tick();
        end
        idle();
    endtask

    task automatic test_write_read();
        wr_req_valid = 1'b1; wr_req_addr = 10'h005; wr_req_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_req_valid = 1'b1; rd_req_addr = 10'h005; rd_rsp_ready = 1'b1;
        tick();
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL wr_rd_accept got=%b want=1", acc); end
        idle();
        tick();
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL wr_rd_early_valid got=%b want=0", obs_valid); end
        tick();
        total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b want=1", obs_valid); end
        total++; if (obs_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data got=%h want=deadbeef", obs_data); end
    endtask

    task automatic test_back_to_back();
        rd_rsp_ready = 1'b1;
        for (int t = 0; t < 18; t++) begin
            rd_req_valid = t < 16;
            rd_req_addr  = AW'(t);
            tick();
            if (t < 16) begin
                total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready t=%0d got=%b want=1", t, obs_ready); end
            end
            if (t >= 2) begin
                total++; if (took !== 1'b1) begin bad++; $display("FAIL b2b_rsp_rate t=%0d got=%b want=1", t, took); end
                total++; if (obs_data !== ref_mem[t-2]) begin bad++; $display("FAIL b2b_data t=%0d got=%h want=%h", t, obs_data, ref_mem[t-2]); end
            end
        end
        idle();
    endtask

    task automatic test_stall();
        int n_acc = 0;
        int n_got = 0;
        rd_rsp_ready = 1'b0;
        for (int t = 0; t < 8; t++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = AW'(10'h020 + t);
            tick();
            if (acc) n_acc++;
            if (t >= 4) begin
                total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL stall_ready t=%0d got=%b want=0", t, obs_ready); end
            end
        end
        total++; if (n_acc != 4) begin bad++; $display("FAIL stall_accepted got=%0d want=4", n_acc); end
        idle();
        rd_rsp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (took) begin
                total++; if (obs_data !== ref_mem[10'h020 + n_got]) begin bad++; $display("FAIL stall_drain_data n=%0d got=%h want=%h", n_got, obs_data, ref_mem[10'h020 + n_got]); end
                n_got++;
            end
        end
        total++; if (n_got != 4) begin bad++; $display("FAIL stall_drained got=%0d want=4", n_got); end
    endtask

    task automatic test_collision();
        rd_rsp_ready = 1'b1;
        wr_req_valid = 1'b1; wr_req_addr = 10'h003; wr_req_data = 32'h000000AA;
        tick();
        wr_req_data = 32'h12345678;
        rd_req_valid = 1'b1; rd_req_addr = 10'h003;
        tick();
`ifdef BRAM_CLIENT_COLLISION_FWD_EN
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL coll_accept got=%b want=1", acc); end
        idle();
`else
        total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL coll_stall got=%b want=0", obs_ready); end
        wr_req_valid = 1'b0;
        tick();
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL coll_retry_accept got=%b want=1", acc); end
        idle();
`endif
        tick();
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL coll_early_valid got=%b want=0", obs_valid); end
        tick();
        total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL coll_valid got=%b want=1", obs_valid); end
        total++; if (obs_data !== 32'h12345678) begin bad++; $display("FAIL coll_data got=%h want=12345678", obs_data); end
    endtask

    task automatic test_reset_mid();
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = AW'(10'h040 + i);
            tick();
        end
        idle();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", rd_rsp_valid); end
        total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", rd_req_ready); end
        RST = 1'b0;
        q.delete();
        rd_rsp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale t=%0d got=%b want=0", t, obs_valid); end
        end
        rd_req_valid = 1'b1; rd_req_addr = 10'h044;
        tick();
        idle();
        repeat (2) tick();
        total++; if (obs_valid !== 1'b1 || obs_data !== ref_mem[10'h044]) begin bad++; $display("FAIL rstmid_fresh got=%b/%h want=1/%h", obs_valid, obs_data, ref_mem[10'h044]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            wr_req_valid = $urandom_range(0, 1) == 1;
            wr_req_addr  = AW'($urandom_range(0, 15));
            wr_req_data  = $urandom;
            rd_req_valid = $urandom_range(0, 9) < 7;
            rd_req_addr  = AW'($urandom_range(0, 15));
            rd_rsp_ready = $urandom_range(0, 9) < 6;
            tick();
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
            if (took) begin
                total++; if (underflow) begin bad++; $display("FAIL rand_underflow c=%0d got=valid want=empty", c); end
                else begin
                    total++; if (obs_data !== exp_rsp) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, obs_data, exp_rsp); end
                end
            end
        end
        idle();
        rd_rsp_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (took) begin
                total++; if (underflow || obs_data !== exp_rsp) begin bad++; $display("FAIL rand_drain got=%h want=%h", obs_data, exp_rsp); end
            end
        end
        total++; if (q.size() != 0 || obs_valid !== 1'b0) begin bad++; $display("FAIL rand_leftover got=%0d/%b want=0/0", q.size(), obs_valid); end
    endtask

    initial begin
        test_reset();
        preload();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
